spi_sched: RTL and testbench
============================

SPI_SCHED -- requirements
Module: spi_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the maximum clk cycles to wait for spi_done before aborting.
REQ-002 SHALL have parameter DAT_W, default 32, giving the DAC write word width.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 adc_req  input  1  ADC read request, level-held until adc_gnt.
REQ-006 adc_gnt  output  1  one-cycle pulse; the ADC request is accepted.
REQ-007 adc_data  output  16  read word returned from the SPI master.
REQ-008 adc_vld  output  1  one-cycle pulse; adc_data is valid.
REQ-009 dac_req  input  1  DAC write request, level-held until dac_gnt.
REQ-010 dac_data  input  DAT_W  write word; must be stable while dac_req is high.
REQ-011 dac_gnt  output  1  one-cycle pulse; the DAC request is accepted.
REQ-012 spi_read_flag  output  1  one-cycle start pulse for a 16-bit SPI read.
REQ-013 spi_writ_flag  output  1  one-cycle start pulse for a 32-bit SPI write.
REQ-014 spi_writ_data  output  32  write word to the SPI master; held for the whole transfer.
REQ-015 spi_read_data  input  16  read word from the SPI master.
REQ-016 spi_done  input  1  one-cycle pulse from the SPI master at end of transfer.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 timeout_err  output  1  sticky error flag; cleared only by reset.

Function
REQ-019 SHALL implement the state machine IDLE -> ISSUE -> WAIT -> IDLE, one transfer at a time.
REQ-020 IDLE: when any request is high, SHALL move to ISSUE next cycle and pulse the winner's gnt in that same cycle.
REQ-021 Arbitration: single request wins; if both are high, the requester not served last wins (round-robin); after reset the ADC has priority.
REQ-022 On grant SHALL latch the transfer type; for a write, SHALL latch dac_data into spi_writ_data.
REQ-023 ISSUE: SHALL last exactly one cycle and assert exactly one of spi_read_flag or spi_writ_flag.
REQ-024 WAIT: the timeout counter SHALL count from 0 each clk.
REQ-025 WAIT, spi_done: return to IDLE next cycle; for a read, capture spi_read_data into adc_data and pulse adc_vld the following cycle.
REQ-026 WAIT timeout: if the counter reaches TIMEOUT-1 without spi_done, SHALL set timeout_err, return to IDLE, and pulse no adc_vld.
REQ-027 If spi_done and the timeout coincide, spi_done SHALL win and the transfer completes normally.
REQ-028 spi_done received outside WAIT SHALL be ignored.
REQ-029 A request that drops before its grant SHALL be dropped silently; the round-robin pointer is not updated.
REQ-030 Minimum spacing between successive start flags SHALL be 3 cycles (IDLE, ISSUE, WAIT).
REQ-031 Grant-to-flag latency SHALL be 1 cycle.
REQ-032 spi_writ_data SHALL change only on a DAC grant.

Reset
REQ-033 On rst_n low, asynchronously: state IDLE, all pulses 0, adc_data 0, spi_writ_data 0, busy 0, timeout_err 0, round-robin pointer set to ADC.
REQ-034 Reset mid-transfer SHALL abort immediately without adc_vld; a spi_done arriving after reset is released SHALL be ignored (REQ-028).

Structure
REQ-035 State encodings and the transfer-type constant SHALL live in a shared package, spi_pkg.
REQ-036 The round-robin arbiter SHALL be a sub-module, rr_arb2 (2 requests in, one-hot grant out, pointer update on accept).

Verification
REQ-037 adc_req alone; master returns 16'hA5C3 with spi_done 10 cycles after the flag -> adc_gnt, spi_read_flag 1 cycle later, adc_data=16'hA5C3 with adc_vld.
REQ-038 dac_req with dac_data=32'h1234_5678 -> dac_gnt, spi_writ_flag, spi_writ_data=32'h1234_5678 stable until spi_done, no adc_vld.
REQ-039 adc_req and dac_req held high for 4 transfers -> grant order ADC, DAC, ADC, DAC.
REQ-040 spi_done never arrives, TIMEOUT=64 -> return to IDLE 64 cycles into WAIT, timeout_err=1, no adc_vld, next request still served.
REQ-041 rst_n asserted in WAIT, late spi_done after release -> outputs at reset values, no adc_vld, busy 0.
REQ-042 spi_done in the same cycle as the timeout -> normal completion, timeout_err stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encodings and transfer-type constants for the SPI scheduler
package spi_pkg;
    localparam int SPI_RD_W = 16;
    localparam int SPI_WR_W = 32;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic {XFER_READ, XFER_WRITE} xfer_t;
endpackage

// File: rtl/spi_sched_if.sv
// spi_sched_if: requester and SPI-master signals of the scheduler; slave is the scheduler side
interface spi_sched_if #(parameter int DAT_W = 32);
    logic                          adc_req;
    logic                          adc_gnt;
    logic [spi_pkg::SPI_RD_W-1:0]  adc_data;
    logic                          adc_vld;
    logic                          dac_req;
    logic [DAT_W-1:0]              dac_data;
    logic                          dac_gnt;
    logic                          spi_read_flag;
    logic                          spi_writ_flag;
    logic [spi_pkg::SPI_WR_W-1:0]  spi_writ_data;
    logic [spi_pkg::SPI_RD_W-1:0]  spi_read_data;
    logic                          spi_done;
    logic                          busy;
    logic                          timeout_err;
    modport slave (
        input  adc_req, dac_req, dac_data, spi_read_data, spi_done,
        output adc_gnt, adc_data, adc_vld, dac_gnt, spi_read_flag, spi_writ_flag,
               spi_writ_data, busy, timeout_err
    );
    modport master (
        output adc_req, dac_req, dac_data, spi_read_data, spi_done,
        input  adc_gnt, adc_data, adc_vld, dac_gnt, spi_read_flag, spi_writ_flag,
               spi_writ_data, busy, timeout_err
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; bit 0 is ADC, bit 1 is DAC, ptr names the favoured side
module rr_arb2
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    xfer_t ptr;
    assign gnt[0] = en && req[0] && (!req[1] || ptr == XFER_READ);
    assign gnt[1] = en && req[1] && (!req[0] || ptr == XFER_WRITE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= XFER_READ;
        else if (|gnt) ptr <= gnt[0] ? XFER_WRITE : XFER_READ;
    end
endmodule

// File: rtl/spi_sched.sv
// spi_sched: schedules ADC reads and DAC writes onto one SPI master, one transfer at a time
module spi_sched
    import spi_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int DAT_W   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_sched_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t         state, state_nx;
    xfer_t          xfer;
    logic [CW-1:0]  cnt;
    logic [1:0]     gnt;
    logic [DAT_W-1:0] wd;
    logic           done, tmo;
    assign wd   = bus.dac_data;
    assign done = state == S_WAIT && bus.spi_done;
    assign tmo  = state == S_WAIT && !bus.spi_done && cnt == CW'(TIMEOUT - 1);
    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == S_IDLE),
        .req   ({bus.dac_req, bus.adc_req}),
        .gnt   (gnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx          = state;
        bus.adc_gnt       = gnt[0];
        bus.dac_gnt       = gnt[1];
        bus.spi_read_flag = state == S_ISSUE && xfer == XFER_READ;
        bus.spi_writ_flag = state == S_ISSUE && xfer == XFER_WRITE;
        bus.busy          = state != S_IDLE;
        case (state)
            S_IDLE:  if (|gnt) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (done || tmo) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer              <= XFER_READ;
            cnt               <= '0;
            bus.spi_writ_data <= '0;
            bus.adc_data      <= '0;
            bus.adc_vld       <= 1'b0;
            bus.timeout_err   <= 1'b0;
        end else begin
            cnt         <= state == S_WAIT ? cnt + CW'(1) : '0;
            bus.adc_vld <= done && xfer == XFER_READ;
            if (|gnt) xfer <= gnt[1] ? XFER_WRITE : XFER_READ;
            if (gnt[1]) bus.spi_writ_data <= SPI_WR_W'(wd);
            if (done && xfer == XFER_READ) bus.adc_data <= bus.spi_read_data;
            if (tmo) bus.timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_sched.sv
// tb_spi_sched: directed scenario tasks for spi_sched with hand-computed expectations
module tb_spi_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    spi_sched_if #(.DAT_W(32)) bus ();
    spi_sched #(.TIMEOUT(64), .DAT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.adc_data !== 16'h0) begin n_fail++; $display("FAIL reset_adc_data got %h want 0000", bus.adc_data); end
        n_checks++; if (bus.spi_writ_data !== 32'h0) begin n_fail++; $display("FAIL reset_writ_data got %h want 0", bus.spi_writ_data); end
        n_checks++; if ({bus.adc_vld, bus.timeout_err, bus.spi_read_flag, bus.spi_writ_flag} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0000", {bus.adc_vld, bus.timeout_err, bus.spi_read_flag, bus.spi_writ_flag}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_adc_read();
        bus.adc_req = 1'b1;
        #1;
        n_checks++; if ({bus.adc_gnt, bus.dac_gnt} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt got %b want 10", {bus.adc_gnt, bus.dac_gnt}); end
        tick();
        bus.adc_req = 1'b0;
        n_checks++; if ({bus.spi_read_flag, bus.spi_writ_flag, bus.busy} !== 3'b101) begin n_fail++; $display("FAIL rd_flag got %b want 101", {bus.spi_read_flag, bus.spi_writ_flag, bus.busy}); end
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 3) begin
                bus.dac_req = 1'b1;
                #1;
                n_checks++; if (bus.dac_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_busy_gnt got %b want 0", bus.dac_gnt); end
                bus.dac_req = 1'b0;
            end
        end
        tick();
        bus.spi_done = 1'b1;
        bus.spi_read_data = 16'hA5C3;
        tick();
        bus.spi_done = 1'b0;
        n_checks++; if ({bus.adc_vld, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL rd_vld got %b want 10", {bus.adc_vld, bus.busy}); end
        n_checks++; if (bus.adc_data !== 16'hA5C3) begin n_fail++; $display("FAIL rd_data got %h want a5c3", bus.adc_data); end
        tick();
        n_checks++; if (bus.adc_vld !== 1'b0) begin n_fail++; $display("FAIL rd_vld_pulse got %b want 0", bus.adc_vld); end
    endtask

    task automatic test_dac_write();
        bus.dac_req = 1'b1;
        bus.dac_data = 32'h1234_5678;
        #1;
        n_checks++; if ({bus.adc_gnt, bus.dac_gnt} !== 2'b01) begin n_fail++; $display("FAIL wr_gnt got %b want 01", {bus.adc_gnt, bus.dac_gnt}); end
        tick();
        bus.dac_req = 1'b0;
        bus.dac_data = 32'hDEAD_BEEF;
        n_checks++; if ({bus.spi_read_flag, bus.spi_writ_flag} !== 2'b01) begin n_fail++; $display("FAIL wr_flag got %b want 01", {bus.spi_read_flag, bus.spi_writ_flag}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (bus.spi_writ_data !== 32'h1234_5678 || bus.adc_vld !== 1'b0) begin n_fail++; $display("FAIL wr_hold got %h/%b want 12345678/0", bus.spi_writ_data, bus.adc_vld); end
        end
        bus.spi_done = 1'b1;
        tick();
        bus.spi_done = 1'b0;
        n_checks++; if ({bus.busy, bus.adc_vld} !== 2'b00) begin n_fail++; $display("FAIL wr_end got %b want 00", {bus.busy, bus.adc_vld}); end
        n_checks++; if (bus.spi_writ_data !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_data_after got %h want 12345678", bus.spi_writ_data); end
    endtask

    task automatic test_back_to_back();
        bus.adc_req = 1'b1;
        bus.dac_req = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic rd;
            rd = (k % 2) == 0;
            n_checks++; if ({bus.adc_gnt, bus.dac_gnt} !== {rd, !rd}) begin n_fail++; $display("FAIL b2b_gnt%0d got %b want %b", k, {bus.adc_gnt, bus.dac_gnt}, {rd, !rd}); end
            tick();
            n_checks++; if ({bus.spi_read_flag, bus.spi_writ_flag} !== {rd, !rd}) begin n_fail++; $display("FAIL b2b_flag%0d got %b want %b", k, {bus.spi_read_flag, bus.spi_writ_flag}, {rd, !rd}); end
            tick();
            bus.spi_done = 1'b1;
            bus.spi_read_data = 16'h1111 * 16'(k + 1);
            if (k == 3) begin
                bus.adc_req = 1'b0;
                bus.dac_req = 1'b0;
            end
            tick();
            bus.spi_done = 1'b0;
            #1;
            n_checks++; if (bus.adc_vld !== rd) begin n_fail++; $display("FAIL b2b_vld%0d got %b want %b", k, bus.adc_vld, rd); end
            if (k == 2) begin
                n_checks++; if (bus.adc_data !== 16'h3333) begin n_fail++; $display("FAIL b2b_data got %h want 3333", bus.adc_data); end
            end
        end
        tick();
    endtask

    task automatic test_done_at_timeout();
        bus.adc_req = 1'b1;
        #1;
        n_checks++; if (bus.adc_gnt !== 1'b1) begin n_fail++; $display("FAIL coin_gnt got %b want 1", bus.adc_gnt); end
        tick();
        bus.adc_req = 1'b0;
        repeat (64) tick();
        bus.spi_done = 1'b1;
        bus.spi_read_data = 16'h0BEE;
        tick();
        bus.spi_done = 1'b0;
        n_checks++; if ({bus.busy, bus.timeout_err, bus.adc_vld} !== 3'b001) begin n_fail++; $display("FAIL coin_end got %b want 001", {bus.busy, bus.timeout_err, bus.adc_vld}); end
        n_checks++; if (bus.adc_data !== 16'h0BEE) begin n_fail++; $display("FAIL coin_data got %h want 0bee", bus.adc_data); end
        tick();
    endtask

    task automatic test_timeout();
        bus.adc_req = 1'b1;
        #1;
        tick();
        bus.adc_req = 1'b0;
        repeat (64) tick();
        n_checks++; if ({bus.busy, bus.timeout_err} !== 2'b10) begin n_fail++; $display("FAIL to_last_wait got %b want 10", {bus.busy, bus.timeout_err}); end
        tick();
        n_checks++; if ({bus.busy, bus.timeout_err, bus.adc_vld} !== 3'b010) begin n_fail++; $display("FAIL to_abort got %b want 010", {bus.busy, bus.timeout_err, bus.adc_vld}); end
        tick();
        n_checks++; if ({bus.timeout_err, bus.adc_vld} !== 2'b10) begin n_fail++; $display("FAIL to_sticky got %b want 10", {bus.timeout_err, bus.adc_vld}); end
        bus.dac_req = 1'b1;
        bus.dac_data = 32'hCAFE_F00D;
        #1;
        n_checks++; if (bus.dac_gnt !== 1'b1) begin n_fail++; $display("FAIL to_next_gnt got %b want 1", bus.dac_gnt); end
        tick();
        bus.dac_req = 1'b0;
        n_checks++; if (bus.spi_writ_flag !== 1'b1 || bus.spi_writ_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL to_next_wr got %b/%h want 1/cafef00d", bus.spi_writ_flag, bus.spi_writ_data); end
        tick();
        bus.spi_done = 1'b1;
        tick();
        bus.spi_done = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL to_next_end got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bus.adc_req = 1'b1;
        #1;
        tick();
        bus.adc_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.busy, bus.timeout_err, bus.adc_vld, bus.spi_read_flag} !== 4'b0) begin n_fail++; $display("FAIL rm_async got %b want 0000", {bus.busy, bus.timeout_err, bus.adc_vld, bus.spi_read_flag}); end
        n_checks++; if (bus.adc_data !== 16'h0 || bus.spi_writ_data !== 32'h0) begin n_fail++; $display("FAIL rm_data got %h/%h want 0/0", bus.adc_data, bus.spi_writ_data); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus.spi_done = 1'b1;
        bus.spi_read_data = 16'hFFFF;
        tick();
        bus.spi_done = 1'b0;
        n_checks++; if ({bus.busy, bus.adc_vld} !== 2'b00) begin n_fail++; $display("FAIL rm_late_done got %b want 00", {bus.busy, bus.adc_vld}); end
        tick();
        n_checks++; if (bus.adc_vld !== 1'b0 || bus.adc_data !== 16'h0) begin n_fail++; $display("FAIL rm_no_vld got %b/%h want 0/0000", bus.adc_vld, bus.adc_data); end
        bus.adc_req = 1'b1;
        bus.dac_req = 1'b1;
        #1;
        n_checks++; if ({bus.adc_gnt, bus.dac_gnt} !== 2'b10) begin n_fail++; $display("FAIL rm_ptr got %b want 10", {bus.adc_gnt, bus.dac_gnt}); end
        tick();
        bus.adc_req = 1'b0;
        bus.dac_req = 1'b0;
        tick();
        bus.spi_done = 1'b1;
        tick();
        bus.spi_done = 1'b0;
        tick();
    endtask

    initial begin
        bus.adc_req = 1'b0;
        bus.dac_req = 1'b0;
        bus.dac_data = '0;
        bus.spi_read_data = '0;
        bus.spi_done = 1'b0;
        test_reset();
        test_adc_read();
        test_dac_write();
        test_back_to_back();
        test_done_at_timeout();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
